nios2_mulx_sequencer: RTL and testbench



---
 rtl/nios2_mulx_pkg.sv | 35 +++
 rtl/nios2_mulx_lane_mult.sv | 47 ++++
 rtl/nios2_mulx_sequencer.sv | 144 ++++++++++++++
 tb/tb_nios2_mulx_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/nios2_mulx_pkg.sv
// rtl/nios2_mulx_pkg.sv - shared types and constants for the multi-cycle multiply sequencer
package nios2_mulx_pkg;

   localparam int LANE_W = 16;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULXUU = 2'b01,
      OP_MULXSU = 2'b10,
      OP_MULXSS = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FIX,
      HOLD
   } state_e;

   localparam logic [5:0] SHIFT_0 = 6'd0;
   localparam logic [5:0] SHIFT_1 = 6'd16;
   localparam logic [5:0] SHIFT_2 = 6'd16;
   localparam logic [5:0] SHIFT_3 = 6'd32;

   function automatic logic [5:0] lane_shift(input logic [1:0] idx);
      case (idx)
         2'd0:    lane_shift = SHIFT_0;
         2'd1:    lane_shift = SHIFT_1;
         2'd2:    lane_shift = SHIFT_2;
         default: lane_shift = SHIFT_3;
      endcase
   endfunction

endpackage

// File: rtl/nios2_mulx_lane_mult.sv
// rtl/nios2_mulx_lane_mult.sv - pipelined 16x16 unsigned lane multiplier
// The partial-product index and a valid bit ride along so the accumulator knows the shift.
module nios2_mulx_lane_mult
   import nios2_mulx_pkg::*;
#(
   parameter int MUL_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear_i,
   input  logic                valid_i,
   input  logic [1:0]          idx_i,
   input  logic [LANE_W-1:0]   a_i,
   input  logic [LANE_W-1:0]   b_i,
   output logic                valid_o,
   output logic [1:0]          idx_o,
   output logic [2*LANE_W-1:0] prod_o
);

   logic [2*LANE_W-1:0]  prod_q [MUL_LATENCY];
   logic [1:0]           idx_q  [MUL_LATENCY];
   logic [MUL_LATENCY-1:0] valid_q;

   always_ff @(posedge clk) begin
      if (!reset_n || clear_i) begin
         valid_q <= '0;
         for (int i = 0; i < MUL_LATENCY; i++) begin
            prod_q[i] <= '0;
            idx_q[i]  <= '0;
         end
      end else begin
         valid_q[0] <= valid_i;
         idx_q[0]   <= idx_i;
         prod_q[0]  <= {{LANE_W{1'b0}}, a_i} * {{LANE_W{1'b0}}, b_i};
         for (int i = 1; i < MUL_LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            idx_q[i]   <= idx_q[i-1];
            prod_q[i]  <= prod_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[MUL_LATENCY-1];
   assign idx_o   = idx_q[MUL_LATENCY-1];
   assign prod_o  = prod_q[MUL_LATENCY-1];

endmodule

// File: rtl/nios2_mulx_sequencer.sv
// rtl/nios2_mulx_sequencer.sv - 32x32 multiply built from four lane partial products
// MULX_EARLY_OUT_EN: skip the (a_hi,b_hi) issue for op=mul.
module nios2_mulx_sequencer
   import nios2_mulx_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int MUL_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   input  logic              flush,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [DATA_W-1:0] result
);

   if (DATA_W != 32 || DATA_W != 2*LANE_W || MUL_LATENCY < 1 || MUL_LATENCY > 3) begin : g_bad_cfg
      $error("nios2_mulx_sequencer: unsupported DATA_W or MUL_LATENCY");
   end

   state_e              state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic [1:0]          drain_q, drain_d;
   op_e                 op_q;
   logic [DATA_W-1:0]   a_q, b_q;
   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic [DATA_W-1:0]   corr, hi;
   logic [1:0]          last_idx;
   logic                accept;

   logic                lane_valid;
   logic [1:0]          lane_idx;
   logic [2*LANE_W-1:0] lane_prod;

`ifdef MULX_EARLY_OUT_EN
   assign last_idx = (op_q == OP_MUL) ? 2'd2 : 2'd3;
`else
   assign last_idx = 2'd3;
`endif

   assign start_ready  = (state_q == IDLE);
   assign result_valid = (state_q == HOLD);
   assign result       = result_q;
   assign accept       = start_valid && start_ready;

   nios2_mulx_lane_mult #(
      .MUL_LATENCY (MUL_LATENCY)
   ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (flush && (state_q != IDLE)),
      .valid_i (state_q == ISSUE),
      .idx_i   (idx_q),
      .a_i     (idx_q[0] ? a_q[DATA_W-1:LANE_W] : a_q[LANE_W-1:0]),
      .b_i     (idx_q[1] ? b_q[DATA_W-1:LANE_W] : b_q[LANE_W-1:0]),
      .valid_o (lane_valid),
      .idx_o   (lane_idx),
      .prod_o  (lane_prod)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      drain_d  = drain_q;
      acc_d    = acc_q;
      result_d = result_q;
      corr     = '0;
      hi       = acc_q[2*DATA_W-1:DATA_W];

      if (lane_valid) begin
         acc_d = acc_q + ({{DATA_W{1'b0}}, lane_prod} << lane_shift(lane_idx));
      end

      case (state_q)
         IDLE: begin
            if (start_valid) begin
               state_d = ISSUE;
               idx_d   = '0;
               acc_d   = '0;
            end
         end
         ISSUE: begin
            if (idx_q == last_idx) begin
               state_d = DRAIN;
               drain_d = '0;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         DRAIN: begin
            if (drain_q == 2'(MUL_LATENCY-1)) state_d = FIX;
            else drain_d = drain_q + 2'd1;
         end
         FIX: begin
            // Unsigned product turned signed: subtract the other operand for each negative input.
            case (op_q)
               OP_MULXSS: corr = (a_q[DATA_W-1] ? b_q : '0) + (b_q[DATA_W-1] ? a_q : '0);
               OP_MULXSU: corr = a_q[DATA_W-1] ? b_q : '0;
               default:   corr = '0;
            endcase
            hi       = acc_q[2*DATA_W-1:DATA_W] - corr;
            result_d = (op_q == OP_MUL) ? acc_q[DATA_W-1:0] : hi;
            state_d  = HOLD;
         end
         HOLD: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (flush && (state_q != IDLE)) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         drain_q  <= '0;
         op_q     <= OP_MUL;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         drain_q  <= drain_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         if (accept) begin
            op_q <= op_e'(op);
            a_q  <= src1;
            b_q  <= src2;
         end
      end
   end

endmodule

// File: tb/tb_nios2_mulx_sequencer.sv
// tb/tb_nios2_mulx_sequencer.sv - directed self-checking bench for the multiply sequencer
module tb_nios2_mulx_sequencer;

`ifdef MULX_EARLY_OUT_EN
   localparam int MUL_LAT = 5;
`else
   localparam int MUL_LAT = 6;
`endif
   localparam int MULX_LAT = 6;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_valid;
   logic        start_ready;
   logic [1:0]  op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        flush;
   logic        result_valid;
   logic        result_ready;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   nios2_mulx_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .op           (op),
      .src1         (src1),
      .src2         (src2),
      .flush        (flush),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result       (result)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the handshake edge.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int hold);
      int lat;
      logic [31:0] held;
      check({tag, "_start_ready"}, {31'b0, start_ready}, 32'd1);
      start_valid = 1'b1;
      op          = o;
      src1        = a;
      src2        = b;
      @(posedge clk); #1;
      start_valid = 1'b0;
      src1        = 32'hDEAD_BEEF;
      src2        = 32'h1234_5678;
      lat = 0;
      while (!result_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, result, exp_res);
      held = result;
      for (int i = 0; i < hold; i++) begin
         start_valid = 1'b1;
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, {31'b0, result_valid}, 32'd1);
         check({tag, "_hold_result"}, result, held);
         check({tag, "_hold_start_ready"}, {31'b0, start_ready}, 32'd0);
      end
      start_valid  = 1'b0;
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      check({tag, "_after_hs_ready"}, {31'b0, start_ready}, 32'd1);
      check({tag, "_after_hs_valid"}, {31'b0, result_valid}, 32'd0);
   endtask

   initial begin
      int seen;
      reset_n      = 1'b0;
      start_valid  = 1'b0;
      op           = 2'b00;
      src1         = '0;
      src2         = '0;
      flush        = 1'b0;
      result_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_start_ready", {31'b0, start_ready}, 32'd1);
      check("rst_result_valid", {31'b0, result_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_op("xuu_ff",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MULX_LAT, 0);
      run_op("xss_ff",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MULX_LAT, 0);
      run_op("xss_min",  2'b11, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, MULX_LAT, 0);
      run_op("xsu_ff",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULX_LAT, 0);
      run_op("mul_lane", 2'b00, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, MUL_LAT, 0);
      run_op("mul_ff",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT, 0);
      run_op("xsu_pos",  2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, MULX_LAT, 0);
      run_op("xss_neg",  2'b11, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULX_LAT, 0);
      run_op("xuu_hold", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, MULX_LAT, 3);

      // Flush while issuing idx 2.
      start_valid = 1'b1;
      op          = 2'b01;
      src1        = 32'hFFFF_FFFF;
      src2        = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_start_ready", {31'b0, start_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (result_valid) seen++;
         @(posedge clk); #1;
      end
      check("flush_no_result", seen, 32'd0);
      run_op("mul_after_flush", 2'b00, 32'd3, 32'd5, 32'h0000_000F, MUL_LAT, 0);

      // Reset asserted while in DRAIN.
      start_valid = 1'b1;
      op          = 2'b11;
      src1        = 32'h8000_0000;
      src2        = 32'h7FFF_FFFF;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      check("midrst_start_ready", {31'b0, start_ready}, 32'd1);
      check("midrst_result_valid", {31'b0, result_valid}, 32'd0);
      check("midrst_result", result, 32'd0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (result_valid) seen++;
         @(posedge clk); #1;
      end
      check("midrst_no_result", seen, 32'd0);
      run_op("mul_7x9", 2'b00, 32'd7, 32'd9, 32'h0000_003F, MUL_LAT, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
